// File: rtl/pcgen_pkg.sv
// Shared types and default vectors for the fetch-stage PC generator.
package pcgen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXC  = 2'd1,
    SRC_ERET = 2'd2,
    SRC_BR   = 2'd3
  } redir_src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0040_0004;

  function automatic logic low_bits_set(input logic [63:0] addr, input logic [63:0] mask);
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority select of the redirect source and target: exception > eret > branch.
module pc_redirect_sel
  import pcgen_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  EXC_VECTOR = XLEN'(DEF_EXC_VECTOR)
) (
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [XLEN-1:0]  epc,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  output redir_src_t       src,
  output logic [XLEN-1:0]  target
);

  // Fixed-priority redirect mux
  always_comb begin
    src    = SRC_NONE;
    target = '0;
    if (exc_valid) begin
      src    = SRC_EXC;
      target = EXC_VECTOR;
    end else if (eret_valid) begin
      src    = SRC_ERET;
      target = epc;
    end else if (br_valid) begin
      src    = SRC_BR;
      target = br_target;
    end else begin
      src    = SRC_NONE;
      target = '0;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator with valid/ready request, pending-redirect buffer and fetch counter.
// Optional macro PCGEN_MISALIGN_CHECK_EN adds misaligned-target trapping and misalign_exc.
module pc_gen_unit
  import pcgen_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0]  EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
  parameter int               INC          = 4,
  parameter int               CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic              br_valid,
  input  logic [XLEN-1:0]   br_target,
  input  logic              exc_valid,
  input  logic              eret_valid,
  input  logic [XLEN-1:0]   epc,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_pc,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              halted
`ifdef PCGEN_MISALIGN_CHECK_EN
  ,output logic             misalign_exc
`endif
);

  state_t            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic              pend_valid_r, pend_valid_s;
  logic [XLEN-1:0]   pend_pc_r, pend_pc_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic              req_r;
  logic              halted_r;
  logic              mis_r, mis_s;

  redir_src_t        redir_src_s;
  logic [XLEN-1:0]   redir_target_s;
  logic              redir_valid_s;
  logic              redir_bad_s, pend_bad_s;
  logic [XLEN-1:0]   redir_pc_s, pend_load_pc_s;

  pc_redirect_sel #(
    .XLEN       (XLEN),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_sel (
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .src        (redir_src_s),
    .target     (redir_target_s)
  );

  assign redir_valid_s = (redir_src_s != SRC_NONE);

`ifdef PCGEN_MISALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  assign redir_bad_s  = redir_valid_s && low_bits_set(64'(redir_target_s), 64'(ALIGN_MASK));
  assign pend_bad_s   = pend_valid_r && low_bits_set(64'(pend_pc_r), 64'(ALIGN_MASK));
  assign misalign_exc = mis_r;
`else
  assign redir_bad_s  = 1'b0;
  assign pend_bad_s   = 1'b0;
`endif

  // Misaligned targets trap to the exception vector instead of loading
  assign redir_pc_s     = redir_bad_s ? EXC_VECTOR : redir_target_s;
  assign pend_load_pc_s = pend_bad_s  ? EXC_VECTOR : pend_pc_r;

  // Next-state and next-value decision for the whole fetch control
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    pend_valid_s = pend_valid_r;
    pend_pc_s    = pend_pc_r;
    count_s      = count_r;
    mis_s        = 1'b0;
    if (ena) begin
      case (state_r)
        BOOT: begin
          state_s = RUN;
          if (redir_valid_s) begin
            pc_s  = redir_pc_s;
            mis_s = redir_bad_s;
          end else begin
            pc_s  = pc_r;
          end
        end
        RUN: begin
          if (redir_valid_s) begin
            pc_s  = redir_pc_s;
            mis_s = redir_bad_s;
          end else begin
            pc_s  = pc_r;
          end
          if (halt) begin
            state_s = HALT;
          end else if (redir_valid_s || stall) begin
            state_s = RUN;
          end else begin
            state_s = REQ;
          end
        end
        REQ: begin
          if (fetch_ready) begin
            count_s      = count_r + CNT_W'(1);
            pend_valid_s = 1'b0;
            if (redir_valid_s) begin
              pc_s  = redir_pc_s;
              mis_s = redir_bad_s;
            end else if (pend_valid_r) begin
              pc_s  = pend_load_pc_s;
              mis_s = pend_bad_s;
            end else begin
              pc_s  = pc_r + XLEN'(INC);
            end
            if (halt) begin
              state_s = HALT;
            end else if (stall || redir_valid_s || pend_valid_r) begin
              state_s = RUN;
            end else begin
              state_s = REQ;
            end
          end else if (redir_valid_s) begin
            // Request must stay stable; park the redirect, last one wins
            pend_valid_s = 1'b1;
            pend_pc_s    = redir_target_s;
          end else begin
            pend_valid_s = pend_valid_r;
          end
        end
        HALT: begin
          if (redir_valid_s) begin
            pc_s  = redir_pc_s;
            mis_s = redir_bad_s;
          end else begin
            pc_s  = pc_r;
          end
          if (resume) begin
            state_s = RUN;
          end else begin
            state_s = HALT;
          end
        end
        default: begin
          state_s = BOOT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_VECTOR;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= '0;
      count_r      <= '0;
      req_r        <= 1'b0;
      halted_r     <= 1'b0;
      mis_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      pend_valid_r <= pend_valid_s;
      pend_pc_r    <= pend_pc_s;
      count_r      <= count_s;
      req_r        <= (state_s == REQ);
      halted_r     <= (state_s == HALT);
      mis_r        <= mis_s;
    end
  end

  assign fetch_valid = req_r & ena;
  assign fetch_pc    = pc_r;
  assign fetch_count = count_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (counter narrowed to 4 bits to reach wrap quickly).
module tb_pc_gen_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             stall;
  logic             halt;
  logic             resume;
  logic             br_valid;
  logic [XLEN-1:0]  br_target;
  logic             exc_valid;
  logic             eret_valid;
  logic [XLEN-1:0]  epc;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] fetch_count;
  logic             halted;
`ifdef PCGEN_MISALIGN_CHECK_EN
  logic             misalign_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pc_gen_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_valid   (exc_valid),
    .eret_valid  (eret_valid),
    .epc         (epc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_count (fetch_count),
    .halted      (halted)
`ifdef PCGEN_MISALIGN_CHECK_EN
    ,.misalign_exc (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    br_valid = 1'b0; br_target = '0; exc_valid = 1'b0; eret_valid = 1'b0;
    epc = '0; fetch_ready = 1'b1;
    tick(); tick();
    check("rst_fv", 64'(fetch_valid), 64'd0);
    check("rst_pc", 64'(fetch_pc), 64'h0040_0000);
    check("rst_cnt", 64'(fetch_count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // boot then back-to-back sequential fetches
    rst = 1'b0;
    check("boot_fv", 64'(fetch_valid), 64'd0);
    tick();
    check("run_fv", 64'(fetch_valid), 64'd0);
    tick();
    check("req0_fv", 64'(fetch_valid), 64'd1);
    check("req0_pc", 64'(fetch_pc), 64'h0040_0000);
    tick();
    check("req1_pc", 64'(fetch_pc), 64'h0040_0004);
    tick();
    check("req2_pc", 64'(fetch_pc), 64'h0040_0008);
    check("req2_cnt", 64'(fetch_count), 64'd2);
    tick();
    check("seq_cnt3", 64'(fetch_count), 64'd3);
    check("seq_pc3", 64'(fetch_pc), 64'h0040_000C);

    // branch during a stalled handshake is buffered
    fetch_ready = 1'b0;
    tick();
    check("hold_pc_a", 64'(fetch_pc), 64'h0040_000C);
    br_valid = 1'b1; br_target = 32'h0040_0100;
    tick();
    br_valid = 1'b0;
    check("hold_pc_b", 64'(fetch_pc), 64'h0040_000C);
    check("hold_fv_b", 64'(fetch_valid), 64'd1);
    tick();
    check("hold_pc_c", 64'(fetch_pc), 64'h0040_000C);
    fetch_ready = 1'b1;
    tick();
    check("pend_pc", 64'(fetch_pc), 64'h0040_0100);
    check("pend_fv", 64'(fetch_valid), 64'd0);
    check("pend_cnt", 64'(fetch_count), 64'd4);
    tick();
    check("pend_req_fv", 64'(fetch_valid), 64'd1);
    check("pend_req_pc", 64'(fetch_pc), 64'h0040_0100);

    // exception beats branch on a transfer cycle
    exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h0040_0200;
    tick();
    exc_valid = 1'b0; br_valid = 1'b0;
    check("exc_pc", 64'(fetch_pc), 64'h0040_0004);
    check("exc_fv", 64'(fetch_valid), 64'd0);
    check("exc_cnt", 64'(fetch_count), 64'd5);

    // stall in RUN for four cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_fv", 64'(fetch_valid), 64'd0);
      check("stall_pc", 64'(fetch_pc), 64'h0040_0004);
    end
    stall = 1'b0;
    tick();
    check("unstall_fv", 64'(fetch_valid), 64'd1);
    check("unstall_pc", 64'(fetch_pc), 64'h0040_0004);
    tick();
    check("unstall_pc2", 64'(fetch_pc), 64'h0040_0008);
    check("unstall_cnt", 64'(fetch_count), 64'd6);

    // halt waits for the in-flight request
    fetch_ready = 1'b0; halt = 1'b1;
    tick();
    check("halt_wait_a", 64'(halted), 64'd0);
    check("halt_wait_fv", 64'(fetch_valid), 64'd1);
    tick();
    check("halt_wait_b", 64'(halted), 64'd0);
    fetch_ready = 1'b1;
    tick();
    halt = 1'b0;
    check("halted", 64'(halted), 64'd1);
    check("halt_fv", 64'(fetch_valid), 64'd0);
    check("halt_cnt", 64'(fetch_count), 64'd7);
    tick();
    check("halt_stay", 64'(halted), 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", 64'(halted), 64'd0);
    tick();
    check("resume_fv", 64'(fetch_valid), 64'd1);
    check("resume_pc", 64'(fetch_pc), 64'h0040_000C);

    // ena low masks the request and freezes state
    ena = 1'b0;
    #1;
    check("ena_fv", 64'(fetch_valid), 64'd0);
    tick();
    check("ena_cnt", 64'(fetch_count), 64'd7);
    check("ena_pc", 64'(fetch_pc), 64'h0040_000C);
    ena = 1'b1;
    #1;
    check("ena_back_fv", 64'(fetch_valid), 64'd1);
    tick();
    check("ena_xfer_cnt", 64'(fetch_count), 64'd8);
    check("ena_xfer_pc", 64'(fetch_pc), 64'h0040_0010);

    // async reset mid-handshake
    rst = 1'b1;
    #1;
    check("mrst_fv", 64'(fetch_valid), 64'd0);
    check("mrst_pc", 64'(fetch_pc), 64'h0040_0000);
    check("mrst_cnt", 64'(fetch_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("wrap_start_pc", 64'(fetch_pc), 64'h0040_0000);

    // counter wrap at 2^CNT_W
    repeat (15) tick();
    check("wrap_cnt15", 64'(fetch_count), 64'hF);
    check("wrap_pc15", 64'(fetch_pc), 64'h0040_003C);
    tick();
    check("wrap_cnt0", 64'(fetch_count), 64'd0);
    check("wrap_pc16", 64'(fetch_pc), 64'h0040_0040);

`ifdef PCGEN_MISALIGN_CHECK_EN
    br_valid = 1'b1; br_target = 32'h0040_0102;
    tick();
    br_valid = 1'b0;
    check("mis_pc", 64'(fetch_pc), 64'h0040_0004);
    check("mis_exc", 64'(misalign_exc), 64'd1);
    tick();
    check("mis_exc_clr", 64'(misalign_exc), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator at the head of the fetch stage of the dynamic pipeline.
- Holds the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Selects the next PC by priority: exception, exception-return, branch/jump redirect, sequential increment.
- Buffers redirects that arrive while a request is stalled, and counts accepted fetches.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h00400000, PC value loaded on reset.
- EXC_VECTOR, 32'h00400004, exception handler entry address.
- INC, 4, sequential increment in bytes; must be a power of two.
- CNT_W, 16, width of the accepted-fetch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; when low all state holds and fetch_valid=0.
- stall  in  1  pipeline stall; blocks issue of a new request.
- halt  in  1  enter HALT after any in-flight request completes.
- resume  in  1  leave HALT.
- br_valid  in  1  branch/jump redirect request.
- br_target  in  XLEN  branch/jump target.
- exc_valid  in  1  exception redirect to EXC_VECTOR.
- eret_valid  in  1  exception return.
- epc  in  XLEN  exception-return target.
- fetch_ready  in  1  instruction memory accepts the request.
- fetch_valid  out  1  request valid.
- fetch_pc  out  XLEN  request address.
- fetch_count  out  CNT_W  number of accepted fetches, wraps modulo 2^CNT_W.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async): state=BOOT, pc=RESET_VECTOR, pend_valid=0, pend_pc=0, fetch_count=0, fetch_valid=0, halted=0. fetch_pc always equals pc.
- Transfer happens when fetch_valid && fetch_ready. fetch_valid is a registered decision; once high, fetch_pc and fetch_valid stay stable until transfer (AXI-style), regardless of stall, halt or redirects.
- Redirect selection (one cycle): exc_valid > eret_valid > br_valid. Targets are EXC_VECTOR, epc and br_target respectively.
- States:
  - BOOT: one cycle, fetch_valid=0; then goes to RUN. A redirect during BOOT loads pc directly.
  - RUN, fetch_valid=0:
    - A redirect loads pc directly; fetch_valid stays 0 for that cycle.
    - Otherwise, if !stall, fetch_valid rises next cycle (→ REQ).
    - halt → HALT.
  - REQ, fetch_valid=1:
    - A redirect without transfer is written into pend (a later, higher-priority redirect overwrites pend; equal or lower priority also overwrites, last-wins).
    - On transfer:
      - fetch_count+=1.
      - pc ← same-cycle redirect if present, else pend_pc if pend_valid, else pc+INC (wraps mod 2^XLEN).
      - pend_valid←0.
    - After transfer:
      - If halt → HALT.
      - Else if stall or a redirect was applied → RUN with fetch_valid=0.
      - Else stay in REQ (back-to-back issue, one fetch per cycle).
  - HALT: halted=1, fetch_valid=0. Redirects load pc. resume → RUN. A simultaneous halt and resume resolves to resume.
- ena=0: no state changes, fetch_valid forced 0 combinationally; any pending request re-presents unchanged when ena returns.
- Reset mid-handshake: request dropped immediately, no count increment.

Optional Feature:
- Macro: PCGEN_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output misalign_exc (1 bit, reset 0).
  - Any selected redirect target with low log2(INC) bits nonzero is not loaded.
  - Instead, pc←EXC_VECTOR and misalign_exc pulses high for one cycle.
  - The same rule applies when pend is consumed.
- Without the macro: targets are loaded verbatim, no extra port.

Decomposition:
- Shared package pcgen_pkg:
  - state enum {BOOT, RUN, REQ, HALT}.
  - Redirect-source enum {NONE, EXC, ERET, BR}.
  - Default vector constants.
- Sub-module pc_redirect_sel: combinational priority select of target and source, instanced once.
- Everything else lives in the top module.

Test Plan:
- Release rst with fetch_ready=1 → cycle 1 fetch_valid=0; then fetch_pc 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; fetch_count=3.
- Hold fetch_ready=0 for 3 cycles; pulse br_valid with br_target=0x00400100 in cycle 2 → fetch_pc unchanged until transfer; next request is 0x00400100.
- Same cycle exc_valid=1, br_valid=1, br_target=0x00400200 during REQ with transfer → next pc=0x00400004 (EXC_VECTOR).
- stall=1 for 4 cycles in RUN → fetch_valid=0, pc constant; release → issue resumes at the held pc.
- halt while REQ and fetch_ready=0 → halted stays 0 until transfer, then 1; resume → next fetch at pc+4.
- With PCGEN_MISALIGN_CHECK_EN: br_target=0x00400102 → pc=0x00400004 and misalign_exc pulses 1 cycle. Separately, fetch_count at 16'hFFFF plus one transfer → 0.
